// File: rtl/axil_rr_arbiter.sv
// Round-robin arbiter that shares one AXI-Lite slave between NUM AXI-Lite masters.
// Exactly one complete write (AW+W+B) or read (AR+R) is granted at a time.
module axil_rr_arbiter #(
    parameter int NUM    = 2,
    parameter int ADDR_W = 6,
    localparam int GW    = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [NUM*ADDR_W-1:0] s_awaddr,
    input  logic [NUM-1:0]        s_awvalid,
    output logic [NUM-1:0]        s_awready,
    input  logic [NUM*32-1:0]     s_wdata,
    input  logic [NUM*4-1:0]      s_wstrb,
    input  logic [NUM-1:0]        s_wvalid,
    output logic [NUM-1:0]        s_wready,
    output logic [NUM*2-1:0]      s_bresp,
    output logic [NUM-1:0]        s_bvalid,
    input  logic [NUM-1:0]        s_bready,
    input  logic [NUM*ADDR_W-1:0] s_araddr,
    input  logic [NUM-1:0]        s_arvalid,
    output logic [NUM-1:0]        s_arready,
    output logic [NUM*32-1:0]     s_rdata,
    output logic [NUM*2-1:0]      s_rresp,
    output logic [NUM-1:0]        s_rvalid,
    input  logic [NUM-1:0]        s_rready,

    output logic [ADDR_W-1:0]     m_awaddr,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [31:0]           m_wdata,
    output logic [3:0]            m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    output logic [ADDR_W-1:0]     m_araddr,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [31:0]           m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready,

    output logic [GW-1:0]         grant,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   ptr_q, ptr_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;

    logic [NUM-1:0]  wreq, rreq, req;
    logic [NUM-1:0]  req_rot, wreq_rot;
    logic            found, pick_wr;
    int              pick_i, next_i;
    int              gsel;
    logic            aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign wreq = s_awvalid;
    assign rreq = s_arvalid;
    assign req  = wreq | rreq;

    // Rotate so bit 0 is the master at ptr; the first set bit is the next winner.
    assign req_rot  = (req  >> ptr_q) | (req  << (NUM - int'(ptr_q)));
    assign wreq_rot = (wreq >> ptr_q) | (wreq << (NUM - int'(ptr_q)));

    assign gsel  = int'(grant_q);
    assign aw_hs = m_awvalid & m_awready;
    assign w_hs  = m_wvalid  & m_wready;
    assign b_hs  = m_bvalid  & m_bready;
    assign ar_hs = m_arvalid & m_arready;
    assign r_hs  = m_rvalid  & m_rready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        found     = 1'b0;
        pick_wr   = 1'b0;
        pick_i    = 0;
        next_i    = 0;
        for (int k = 0; k < NUM; k++) begin
            if (!found && req_rot[k]) begin
                found   = 1'b1;
                pick_wr = wreq_rot[k];
                pick_i  = int'(ptr_q) + k;
                if (pick_i >= NUM) pick_i = pick_i - NUM;
            end
        end
        next_i = (pick_i + 1 >= NUM) ? 0 : pick_i + 1;

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick_i[GW-1:0];
                    ptr_d   = next_i[GW-1:0];
                    state_d = pick_wr ? WR_ADDR : RD_ADDR;
                end
            end
            WR_ADDR: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q  | w_hs;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_RESP;
                end
            end
            WR_RESP: if (b_hs)  state_d = IDLE;
            RD_ADDR: if (ar_hs) state_d = RD_DATA;
            RD_DATA: if (r_hs)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_awready = '0;
        s_wready  = '0;
        s_bresp   = '0;
        s_bvalid  = '0;
        s_arready = '0;
        s_rdata   = '0;
        s_rresp   = '0;
        s_rvalid  = '0;
        m_awaddr  = s_awaddr[gsel*ADDR_W +: ADDR_W];
        m_wdata   = s_wdata[gsel*32 +: 32];
        m_wstrb   = s_wstrb[gsel*4 +: 4];
        m_araddr  = s_araddr[gsel*ADDR_W +: ADDR_W];
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        grant     = grant_q;
        busy      = (state_q != IDLE);

        case (state_q)
            WR_ADDR: begin
                // Each channel is masked once it has completed so it is issued only once.
                m_awvalid          = s_awvalid[grant_q] & ~aw_done_q;
                m_wvalid           = s_wvalid[grant_q]  & ~w_done_q;
                s_awready[grant_q] = m_awready & ~aw_done_q;
                s_wready[grant_q]  = m_wready  & ~w_done_q;
            end
            WR_RESP: begin
                m_bready               = s_bready[grant_q];
                s_bvalid[grant_q]      = m_bvalid;
                s_bresp[gsel*2 +: 2]   = m_bresp;
            end
            RD_ADDR: begin
                m_arvalid          = s_arvalid[grant_q];
                s_arready[grant_q] = m_arready;
            end
            RD_DATA: begin
                m_rready               = s_rready[grant_q];
                s_rvalid[grant_q]      = m_rvalid;
                s_rdata[gsel*32 +: 32] = m_rdata;
                s_rresp[gsel*2 +: 2]   = m_rresp;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axil_rr_arbiter.sv
// Scoreboard bench for axil_rr_arbiter: two masters, a small register-file slave,
// and a monitor that pops expected grants and responses as the DUT presents them.
module tb_axil_rr_arbiter;

    localparam int NUM = 2;
    localparam int AW  = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [AW-1:0] awaddr_m [NUM];
    logic          awvalid_m[NUM];
    logic [31:0]   wdata_m  [NUM];
    logic [3:0]    wstrb_m  [NUM];
    logic          wvalid_m [NUM];
    logic          bready_m [NUM];
    logic [AW-1:0] araddr_m [NUM];
    logic          arvalid_m[NUM];
    logic          rready_m [NUM];

    logic [NUM*AW-1:0] s_awaddr, s_araddr;
    logic [NUM-1:0]    s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [NUM-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
    logic [NUM*32-1:0] s_wdata, s_rdata;
    logic [NUM*4-1:0]  s_wstrb;
    logic [NUM*2-1:0]  s_bresp, s_rresp;

    logic [AW-1:0] m_awaddr, m_araddr;
    logic          m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic          m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0]   m_wdata, m_rdata;
    logic [3:0]    m_wstrb;
    logic [1:0]    m_bresp, m_rresp;
    logic [0:0]    grant;
    logic          busy;

    for (genvar i = 0; i < NUM; i++) begin : g_pack
        assign s_awaddr[i*AW +: AW] = awaddr_m[i];
        assign s_awvalid[i]         = awvalid_m[i];
        assign s_wdata[i*32 +: 32]  = wdata_m[i];
        assign s_wstrb[i*4 +: 4]    = wstrb_m[i];
        assign s_wvalid[i]          = wvalid_m[i];
        assign s_bready[i]          = bready_m[i];
        assign s_araddr[i*AW +: AW] = araddr_m[i];
        assign s_arvalid[i]         = arvalid_m[i];
        assign s_rready[i]          = rready_m[i];
    end

    axil_rr_arbiter #(.NUM(NUM), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .grant(grant), .busy(busy)
    );

    // Downstream register-file slave with optional AW stall and read delay.
    int          aw_stall = 0;
    int          rd_delay = 0;
    int          aw_cnt, rd_cnt, wr_count;
    logic        aw_got, w_got, bvalid_r, rd_pend, rvalid_r;
    logic [AW-1:0] aw_a, ar_a;
    logic [31:0] w_d, rdata_r;
    logic [3:0]  w_s;
    logic [31:0] mem[16];

    assign m_awready = (aw_cnt >= aw_stall) && !aw_got && !bvalid_r;
    assign m_wready  = !w_got && !bvalid_r;
    assign m_bvalid  = bvalid_r;
    assign m_bresp   = 2'b00;
    assign m_arready = !rd_pend && !rvalid_r;
    assign m_rvalid  = rvalid_r;
    assign m_rdata   = rdata_r;
    assign m_rresp   = 2'b00;

    always @(posedge clk) begin
        if (rst) begin
            aw_cnt <= 0; rd_cnt <= 0; wr_count <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; bvalid_r <= 1'b0;
            rd_pend <= 1'b0; rvalid_r <= 1'b0; rdata_r <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            if (m_awvalid && m_awready) begin
                aw_got <= 1'b1; aw_a <= m_awaddr; aw_cnt <= 0;
            end else if (m_awvalid) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (m_wvalid && m_wready) begin
                w_got <= 1'b1; w_d <= m_wdata; w_s <= m_wstrb;
            end
            if (aw_got && w_got && !bvalid_r) begin
                for (int b = 0; b < 4; b++)
                    if (w_s[b]) mem[aw_a[5:2]][b*8 +: 8] <= w_d[b*8 +: 8];
                bvalid_r <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
                wr_count <= wr_count + 1;
            end
            if (bvalid_r && m_bready) bvalid_r <= 1'b0;
            if (m_arvalid && m_arready) begin
                rd_pend <= 1'b1; ar_a <= m_araddr; rd_cnt <= 0;
            end else if (rd_pend) begin
                if (rd_cnt >= rd_delay) begin
                    rvalid_r <= 1'b1; rdata_r <= mem[ar_a[5:2]]; rd_pend <= 1'b0;
                end else begin
                    rd_cnt <= rd_cnt + 1;
                end
            end
            if (rvalid_r && m_rready) rvalid_r <= 1'b0;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void fail(string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: no handshake within the cycle budget", name);
    endfunction

    typedef struct {
        int          kind;   // 0 = B, 1 = R
        int          m;
        logic [31:0] data;
    } exp_t;

    exp_t rsp_q[$];
    int   gnt_q[$];

    function automatic void expect_b(int m);
        exp_t e;
        e.kind = 0; e.m = m; e.data = '0;
        rsp_q.push_back(e);
    endfunction

    function automatic void expect_r(int m, logic [31:0] d);
        exp_t e;
        e.kind = 1; e.m = m; e.data = d;
        rsp_q.push_back(e);
    endfunction

    function automatic void expect_g(int m);
        gnt_q.push_back(m);
    endfunction

    // Monitor: grant order on each busy rise, responses on each upstream handshake,
    // and the mandatory IDLE cycle after every retired response.
    initial begin
        logic busy_prev;
        logic gap_pend;
        exp_t e;
        busy_prev = 1'b0;
        gap_pend  = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (gap_pend) begin
                check("idle_gap", 32'(busy), 32'd0);
                gap_pend = 1'b0;
            end
            if (busy && !busy_prev) begin
                if (gnt_q.size() == 0) fail("unexpected_grant");
                else check("grant_order", 32'(grant), 32'(gnt_q.pop_front()));
            end
            for (int i = 0; i < NUM; i++) begin
                if (s_bvalid[i] && s_bready[i]) begin
                    gap_pend = 1'b1;
                    if (rsp_q.size() == 0) fail("unexpected_b");
                    else begin
                        e = rsp_q.pop_front();
                        check("b_kind", 32'd0, 32'(e.kind));
                        check("b_master", 32'(i), 32'(e.m));
                        check("b_resp", 32'(s_bresp[i*2 +: 2]), 32'd0);
                    end
                end
                if (s_rvalid[i] && s_rready[i]) begin
                    gap_pend = 1'b1;
                    if (rsp_q.size() == 0) fail("unexpected_r");
                    else begin
                        e = rsp_q.pop_front();
                        check("r_kind", 32'd1, 32'(e.kind));
                        check("r_master", 32'(i), 32'(e.m));
                        check("r_data", s_rdata[i*32 +: 32], e.data);
                    end
                end
            end
            busy_prev = busy;
        end
    end

    task automatic do_write(input int m, input logic [AW-1:0] addr, input logic [31:0] data,
                            input int w_lead);
        logic aw_hs, w_hs, b_hs, done;
        done = 1'b0;
        awaddr_m[m] = addr;
        wdata_m[m]  = data;
        wstrb_m[m]  = 4'hF;
        wvalid_m[m] = 1'b1;
        bready_m[m] = 1'b1;
        repeat (w_lead) @(negedge clk);
        awvalid_m[m] = 1'b1;
        for (int c = 0; c < 100 && !done; c++) begin
            #1;
            aw_hs = awvalid_m[m] & s_awready[m];
            w_hs  = wvalid_m[m]  & s_wready[m];
            b_hs  = s_bvalid[m]  & bready_m[m];
            @(negedge clk);
            if (aw_hs) awvalid_m[m] = 1'b0;
            if (w_hs)  wvalid_m[m]  = 1'b0;
            if (b_hs) begin bready_m[m] = 1'b0; done = 1'b1; end
        end
        if (!done) fail("write_timeout");
    endtask

    task automatic do_read(input int m, input logic [AW-1:0] addr, input int rr_hold);
        logic ar_hs, r_hs, done;
        int   hold;
        done = 1'b0;
        hold = 0;
        araddr_m[m]  = addr;
        arvalid_m[m] = 1'b1;
        rready_m[m]  = (rr_hold == 0);
        for (int c = 0; c < 100 && !done; c++) begin
            #1;
            ar_hs = arvalid_m[m] & s_arready[m];
            r_hs  = s_rvalid[m]  & rready_m[m];
            if (s_rvalid[m] && !rready_m[m]) hold++;
            @(negedge clk);
            if (ar_hs) arvalid_m[m] = 1'b0;
            if (r_hs) begin rready_m[m] = 1'b0; done = 1'b1; end
            else if (hold >= rr_hold) rready_m[m] = 1'b1;
        end
        if (!done) fail("read_timeout");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_before;
        for (int i = 0; i < NUM; i++) begin
            awaddr_m[i] = '0; awvalid_m[i] = 1'b0; wdata_m[i] = '0; wstrb_m[i] = '0;
            wvalid_m[i] = 1'b0; bready_m[i] = 1'b0; araddr_m[i] = '0;
            arvalid_m[i] = 1'b0; rready_m[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_s_ready", 32'({s_awready, s_wready, s_arready}), 32'd0);
        check("rst_s_valid", 32'({s_bvalid, s_rvalid}), 32'd0);
        check("rst_m_valid", 32'({m_awvalid, m_wvalid, m_arvalid}), 32'd0);
        check("rst_m_ready", 32'({m_bready, m_rready}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single write from master 0; master 1's slice must stay quiet.
        expect_g(0); expect_b(0);
        fork
            do_write(0, 6'h04, 32'hCA55E77E, 0);
            begin
                logic leak;
                leak = 1'b0;
                #1 check("aw_before_grant", 32'(m_awvalid), 32'd0);
                @(negedge clk); #1;
                check("aw_one_cycle", 32'(m_awvalid), 32'd1);
                check("m_awaddr", 32'(m_awaddr), 32'h04);
                check("m_wdata", m_wdata, 32'hCA55E77E);
                for (int c = 0; c < 10; c++) begin
                    leak = leak | s_awready[1] | s_wready[1] | s_bvalid[1];
                    @(negedge clk); #1;
                end
                check("slice1_quiet", 32'(leak), 32'd0);
            end
        join
        @(negedge clk);
        expect_g(0); expect_r(0, 32'hCA55E77E);
        do_read(0, 6'h04, 0);
        @(negedge clk);
        expect_g(1); expect_r(1, 32'hCA55E77E);
        do_read(1, 6'h04, 0);

        // Contention with ptr at 0, then with ptr at 1.
        @(negedge clk);
        expect_g(0); expect_g(1);
        expect_r(0, 32'hCA55E77E); expect_r(1, 32'hCA55E77E);
        fork
            do_read(0, 6'h04, 0);
            do_read(1, 6'h04, 0);
        join
        @(negedge clk);
        expect_g(0); expect_r(0, 32'hCA55E77E);
        do_read(0, 6'h04, 0);
        @(negedge clk);
        expect_g(1); expect_g(0);
        expect_r(1, 32'hCA55E77E); expect_r(0, 32'hCA55E77E);
        fork
            do_read(0, 6'h04, 0);
            do_read(1, 6'h04, 0);
        join

        // W presented three cycles before AW, with the slave stalling AW.
        @(negedge clk);
        aw_stall  = 2;
        wr_before = wr_count;
        expect_g(1); expect_b(1);
        fork
            do_write(1, 6'h08, 32'h12345678, 3);
            begin
                logic seen;
                seen = 1'b0;
                for (int c = 0; c < 30 && !seen; c++) begin
                    #1;
                    if (m_wvalid && m_wready) seen = 1'b1;
                    @(negedge clk);
                end
                if (!seen) fail("w_handshake");
                else begin
                    #1;
                    check("w_first_wvalid_drop", 32'(m_wvalid), 32'd0);
                    check("w_first_aw_pending", 32'(m_awvalid), 32'd1);
                    check("w_first_no_bready", 32'(m_bready), 32'd0);
                end
            end
        join
        aw_stall = 0;
        check("one_write", 32'(wr_count - wr_before), 32'd1);
        @(negedge clk);
        expect_g(0); expect_r(0, 32'h12345678);
        do_read(0, 6'h08, 0);

        // Same master: write and read asserted together, write first.
        @(negedge clk);
        expect_g(0); expect_b(0); expect_g(0); expect_r(0, 32'hDEADBEEF);
        fork
            do_write(0, 6'h0C, 32'hDEADBEEF, 0);
            do_read(0, 6'h0C, 0);
        join

        // Reset while waiting in RD_DATA with no read data yet.
        @(negedge clk);
        rd_delay = 20;
        expect_g(0);
        araddr_m[0]  = 6'h0C;
        arvalid_m[0] = 1'b1;
        rready_m[0]  = 1'b1;
        begin
            logic got;
            got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                #1;
                if (s_arready[0]) got = 1'b1;
                @(negedge clk);
            end
            arvalid_m[0] = 1'b0;
            if (!got) fail("rst_ar_handshake");
        end
        #1;
        check("rst_in_rd_data", 32'(m_rready), 32'd1);
        check("rst_rvalid_low", 32'(m_rvalid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rready_m[0] = 1'b0;
        rd_delay = 0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_grant", 32'(grant), 32'd0);
        check("midrst_valids", 32'({m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid}), 32'd0);
        check("midrst_rready", 32'(m_rready), 32'd0);
        @(negedge clk);
        // ptr is back at 0, so master 0 wins the simultaneous pair.
        expect_g(0); expect_g(1); expect_r(0, 32'h0); expect_r(1, 32'h0);
        fork
            do_read(0, 6'h0C, 0);
            do_read(1, 6'h0C, 0);
        join

        // Backpressure on master 0's R channel while master 1 waits.
        @(negedge clk);
        expect_g(0); expect_b(0);
        do_write(0, 6'h10, 32'h5A5AA5A5, 0);
        @(negedge clk);
        expect_g(0); expect_r(0, 32'h5A5AA5A5); expect_g(1); expect_r(1, 32'h5A5AA5A5);
        fork
            do_read(0, 6'h10, 5);
            begin @(negedge clk); do_read(1, 6'h10, 0); end
            begin
                int c;
                c = 0;
                #1;
                while (!s_rvalid[0] && c < 20) begin
                    @(negedge clk); #1; c++;
                end
                if (!s_rvalid[0]) fail("bp_rvalid");
                else begin
                    for (int k = 0; k < 5; k++) begin
                        check("bp_rdata", s_rdata[31:0], 32'h5A5AA5A5);
                        check("bp_rready", 32'(m_rready), 32'(rready_m[0]));
                        check("bp_grant_held", 32'({busy, grant}), 32'b10);
                        @(negedge clk); #1;
                    end
                end
            end
        join

        repeat (3) @(negedge clk);
        check("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
        check("gnt_q_empty", 32'(gnt_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
